arch_map_table_nw: RTL and testbench
====================================

# arch_map_table_nw

Parametrised Architectural Map Table for the retire stage. Holds the committed logical-to-physical register mapping and accepts up to COMMIT_W retiring instructions per cycle. Returns each superseded physical register to the free list in the same cycle. On a recovery request it runs a multi-cycle walk that streams the whole table to the Rename Map Table, RCV_W entries per cycle, with busy/done handshake and partial-group lane masking.

## Interface
- NUM_LOG, 34: logical registers (table depth); LOG_W = $clog2(NUM_LOG)
- NUM_PHYS, 96: physical registers; PHY_W = $clog2(NUM_PHYS); NUM_PHYS >= NUM_LOG
- COMMIT_W, 4: commit lanes; lane 0 oldest, highest lane youngest
- RCV_W, 4: recovery lanes (RMT write ports), 1..NUM_LOG
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- commit_valid_i  in  COMMIT_W  lane retires an instruction with a destination
- commit_log_i  in  COMMIT_W*LOG_W  logical dest per lane (lane i at [i*LOG_W +: LOG_W])
- commit_phy_i  in  COMMIT_W*PHY_W  new physical mapping per lane
- recover_req_i  in  1  single-cycle pulse from Active List (mispredict/exception)
- release_valid_o  out  COMMIT_W  physical register released this cycle
- release_phy_o  out  COMMIT_W*PHY_W  released physical register per lane
- recover_valid_o  out  RCV_W  lane carries a valid RMT update
- recover_log_o  out  RCV_W*LOG_W  logical index per recovery lane
- recover_phy_o  out  RCV_W*PHY_W  committed mapping per recovery lane
- recover_busy_o  out  1  walk in progress
- recover_done_o  out  1  one-cycle pulse on last walk group

## Operation
- Reset: entry r = r (identity map); FSM = IDLE; walk counter = 0; all outputs 0 (release_phy_o and recover_phy_o are don't-care while their valid is 0).
- Commit, IDLE only. For each lane i with commit_valid_i[i]:
  - Superseded: a younger valid lane j>i has the same dest. Then lane i does not write the table, and release_phy_o[i] = commit_phy_i[i].
  - Otherwise: lane i writes commit_phy_i[i] to entry commit_log_i[i] at the clock edge, and release_phy_o[i] = current (pre-edge) table value of that entry.
  - release_valid_o[i] = commit_valid_i[i]. Combinational, same cycle.
- Invalid lanes never suppress older lanes, write, or release.
- At most one write per entry per cycle, by construction.
- FSM IDLE -> WALK: recover_req_i=1 in IDLE. Counter cleared to 0. Commits present in that same cycle are applied normally.
- FSM WALK: recovery lane k carries entry cnt+k.
  - recover_valid_o[k] = 1 iff cnt+k < NUM_LOG.
  - cnt += RCV_W each cycle. Counter width LOG_W+1, so it never wraps.
  - The last group (cnt+RCV_W >= NUM_LOG) asserts recover_done_o and returns to IDLE on the next edge.
- During WALK, commit_valid_i is a protocol error. Such commits are ignored: no write, release_valid_o = 0. recover_req_i is also ignored.
- recover_busy_o = (state == WALK).

## Timing
- Release: 0-cycle latency. A table write is visible to the read ports from the next cycle.
- recover_req_i sampled at edge T. Group g (entries g*RCV_W..) is presented in cycle T+1+g, g = 0..G-1, where G = ceil(NUM_LOG/RCV_W).
- recover_done_o is high in cycle T+G, together with the final group.
- A new recover_req_i is accepted in cycle T+G+1 at the earliest.
- Recovery data reflects all commits up to and including cycle T.
- reset mid-walk: immediate return to IDLE; identity map restored; busy, done and valids drop asynchronously.

## Structure
- Package amt_pkg holds:
  - default parameters
  - width helper functions (LOG_W, PHY_W, G)
  - typedef enum logic {IDLE, WALK} amt_state_t
- Sub-module amt_regfile: NUM_LOG x PHY_W flop array.
  - COMMIT_W write ports and COMMIT_W + RCV_W async read ports.
  - Async reset to identity.
  - Write enables are already de-duplicated by the parent.
- Parent holds the supersede compare network, release mux, FSM and walk counter.

## Test plan
- Reset, then IDLE with no commits -> all outputs 0. Recover with NUM_LOG=34, RCV_W=4 -> 9 groups, entry r = r, done in the 9th cycle, lanes 2-3 invalid in the last group.
- Lane0 r5->p40, lane2 r5->p41 (both valid) -> release_phy lane0 = 40, lane2 = 5. After the edge, entry 5 = 41.
- Lane1 r7->p50 valid, lane3 r7->p51 invalid -> entry 7 = 50, lane1 releases 7, release_valid[3] = 0.
- Commit lane0 r3->p60 in the same cycle as recover_req -> walk group 0 shows entry 3 = 60. busy high for 9 cycles.
- commit_valid = 4'b1111 and recover_req both asserted during WALK -> no table change, release_valid = 0, walk sequence unaltered.
- reset asserted in the 4th walk cycle -> busy, done and valids go 0 without a clock edge. Table is back to identity; a new recovery walk restarts at entry 0.

Source files
------------

// File: rtl/amt_pkg.sv
// Shared parameters, width helpers and walk FSM state type for the
// architectural map table.
package amt_pkg;

    localparam int unsigned DEF_NUM_LOG  = 34;
    localparam int unsigned DEF_NUM_PHYS = 96;
    localparam int unsigned DEF_COMMIT_W = 4;
    localparam int unsigned DEF_RCV_W    = 4;

    function automatic int unsigned log_w(input int unsigned num_log);
        return (num_log > 1) ? $clog2(num_log) : 1;
    endfunction

    function automatic int unsigned phy_w(input int unsigned num_phys);
        return (num_phys > 1) ? $clog2(num_phys) : 1;
    endfunction

    function automatic int unsigned num_groups(input int unsigned num_log,
                                               input int unsigned rcv_w);
        return (num_log + rcv_w - 1) / rcv_w;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } amt_state_t;

endpackage

// File: rtl/amt_regfile.sv
// Committed logical-to-physical mapping storage: multi-write, multi-read flop
// array that resets to the identity map.
module amt_regfile
    import amt_pkg::*;
#(
    parameter int unsigned NUM_LOG = DEF_NUM_LOG,
    parameter int unsigned LOG_W   = log_w(DEF_NUM_LOG),
    parameter int unsigned PHY_W   = phy_w(DEF_NUM_PHYS),
    parameter int unsigned NUM_WR  = DEF_COMMIT_W,
    parameter int unsigned NUM_RD  = DEF_COMMIT_W + DEF_RCV_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*LOG_W-1:0] wr_addr_i,
    input  logic [NUM_WR*PHY_W-1:0] wr_data_i,
    input  logic [NUM_RD*LOG_W-1:0] rd_addr_i,
    output logic [NUM_RD*PHY_W-1:0] rd_data_o
);

    logic [PHY_W-1:0] mem_q [NUM_LOG];

    // NOTE: this array is architectural state, so it is reset (to identity)
    // unlike a plain data RAM; sequential state uses non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_LOG; r++) begin
                mem_q[r] <= PHY_W'(r);
            end
        end else begin
            for (int r = 0; r < NUM_LOG; r++) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && wr_addr_i[w*LOG_W +: LOG_W] == LOG_W'(r)) begin
                        mem_q[r] <= wr_data_i[w*PHY_W +: PHY_W];
                    end
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (32'(rd_addr_i[k*LOG_W +: LOG_W]) < NUM_LOG) begin
                rd_data_o[k*PHY_W +: PHY_W] = mem_q[rd_addr_i[k*LOG_W +: LOG_W]];
            end
        end
    end

endmodule

// File: rtl/arch_map_table_nw.sv
// Architectural map table: retire-time mapping update with same-cycle release
// of superseded registers, and a grouped recovery walk toward the rename map.
module arch_map_table_nw
    import amt_pkg::*;
#(
    parameter  int unsigned NUM_LOG  = DEF_NUM_LOG,
    parameter  int unsigned NUM_PHYS = DEF_NUM_PHYS,
    parameter  int unsigned COMMIT_W = DEF_COMMIT_W,
    parameter  int unsigned RCV_W    = DEF_RCV_W,
    localparam int unsigned LOG_W    = log_w(NUM_LOG),
    localparam int unsigned PHY_W    = phy_w(NUM_PHYS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COMMIT_W-1:0]       commit_valid_i,
    input  logic [COMMIT_W*LOG_W-1:0] commit_log_i,
    input  logic [COMMIT_W*PHY_W-1:0] commit_phy_i,
    input  logic                      recover_req_i,
    output logic [COMMIT_W-1:0]       release_valid_o,
    output logic [COMMIT_W*PHY_W-1:0] release_phy_o,
    output logic [RCV_W-1:0]          recover_valid_o,
    output logic [RCV_W*LOG_W-1:0]    recover_log_o,
    output logic [RCV_W*PHY_W-1:0]    recover_phy_o,
    output logic                      recover_busy_o,
    output logic                      recover_done_o
);

    localparam int unsigned CNT_W  = LOG_W + 1;
    localparam int unsigned NUM_RD = COMMIT_W + RCV_W;

    amt_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    commit_en;
    logic                    walk_last;
    logic [COMMIT_W-1:0]     superseded;
    logic [COMMIT_W-1:0]     wr_en;
    logic [NUM_RD*LOG_W-1:0] rd_addr;
    logic [NUM_RD*PHY_W-1:0] rd_data;

    assign commit_en = (state_q == IDLE);
    assign walk_last = (32'(cnt_q) + RCV_W >= NUM_LOG);

    // A lane is superseded when any younger valid lane targets the same entry.
    always_comb begin
        superseded = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            for (int j = i + 1; j < COMMIT_W; j++) begin
                if (commit_valid_i[j] &&
                    commit_log_i[j*LOG_W +: LOG_W] == commit_log_i[i*LOG_W +: LOG_W]) begin
                    superseded[i] = 1'b1;
                end
            end
        end
    end

    assign wr_en = {COMMIT_W{commit_en}} & commit_valid_i & ~superseded;

    amt_regfile #(
        .NUM_LOG (NUM_LOG),
        .LOG_W   (LOG_W),
        .PHY_W   (PHY_W),
        .NUM_WR  (COMMIT_W),
        .NUM_RD  (NUM_RD)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (commit_log_i),
        .wr_data_i (commit_phy_i),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        release_valid_o = commit_en ? commit_valid_i : '0;
        release_phy_o   = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (release_valid_o[i]) begin
                release_phy_o[i*PHY_W +: PHY_W] = superseded[i] ? commit_phy_i[i*PHY_W +: PHY_W]
                                                                : rd_data[i*PHY_W +: PHY_W];
            end
        end
    end

    // Read ports: commit lanes first, then one port per recovery lane.
    always_comb begin
        int unsigned idx;
        idx             = 0;
        rd_addr         = '0;
        recover_valid_o = '0;
        recover_log_o   = '0;
        rd_addr[0 +: COMMIT_W*LOG_W] = commit_log_i;
        for (int k = 0; k < RCV_W; k++) begin
            idx = 32'(cnt_q) + k;
            if (state_q == WALK && idx < NUM_LOG) begin
                recover_valid_o[k]                     = 1'b1;
                recover_log_o[k*LOG_W +: LOG_W]        = LOG_W'(idx);
                rd_addr[(COMMIT_W+k)*LOG_W +: LOG_W]   = LOG_W'(idx);
            end
        end
    end

    always_comb begin
        recover_phy_o = '0;
        for (int k = 0; k < RCV_W; k++) begin
            if (recover_valid_o[k]) begin
                recover_phy_o[k*PHY_W +: PHY_W] = rd_data[(COMMIT_W+k)*PHY_W +: PHY_W];
            end
        end
    end

    assign recover_busy_o = (state_q == WALK);
    assign recover_done_o = (state_q == WALK) && walk_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (recover_req_i) begin
                        state_q <= WALK;
                        cnt_q   <= '0;
                    end
                end
                WALK: begin
                    if (walk_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(RCV_W);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arch_map_table_nw.sv
// Directed bench for arch_map_table_nw with a reference mapping model and an
// expected-value queue consumed as the DUT presents results.
module tb_arch_map_table_nw;

    localparam int NL = 34;
    localparam int NP = 96;
    localparam int CW = 4;
    localparam int RW = 4;
    localparam int LW = $clog2(NL);
    localparam int PW = $clog2(NP);
    localparam int G  = (NL + RW - 1) / RW;

    logic             clk;
    logic             reset;
    logic [CW-1:0]    cv;
    logic [CW*LW-1:0] cl;
    logic [CW*PW-1:0] cp;
    logic             req;
    logic [CW-1:0]    release_valid_o;
    logic [CW*PW-1:0] release_phy_o;
    logic [RW-1:0]    recover_valid_o;
    logic [RW*LW-1:0] recover_log_o;
    logic [RW*PW-1:0] recover_phy_o;
    logic             recover_busy_o;
    logic             recover_done_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          model [NL];
    string       sb_tag [$];
    logic [31:0] sb_exp [$];

    arch_map_table_nw #(
        .NUM_LOG  (NL),
        .NUM_PHYS (NP),
        .COMMIT_W (CW),
        .RCV_W    (RW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid_i  (cv),
        .commit_log_i    (cl),
        .commit_phy_i    (cp),
        .recover_req_i   (req),
        .release_valid_o (release_valid_o),
        .release_phy_o   (release_phy_o),
        .recover_valid_o (recover_valid_o),
        .recover_log_o   (recover_log_o),
        .recover_phy_o   (recover_phy_o),
        .recover_busy_o  (recover_busy_o),
        .recover_done_o  (recover_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        if (sb_exp.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_empty: observed %0d expected <queued entry>", obs);
            return;
        end
        tag = sb_tag.pop_front();
        exp = sb_exp.pop_front();
        check(tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_identity();
        for (int r = 0; r < NL; r++) model[r] = r;
    endtask

    task automatic drive_lane(input int i, input bit v, input int lg, input int ph);
        cv[i]            = v;
        cl[i*LW +: LW]   = LW'(lg);
        cp[i*PW +: PW]   = PW'(ph);
    endtask

    // Scan lanes youngest to oldest: the first lane to claim an entry writes
    // it; any older lane hitting a claimed entry releases its own new mapping.
    task automatic expect_commits(input bit accepted);
        bit seen  [NL];
        int rel   [CW];
        bit write [CW];
        for (int r = 0; r < NL; r++) seen[r] = 1'b0;
        for (int i = CW - 1; i >= 0; i--) begin
            int lg;
            int ph;
            lg       = int'(cl[i*LW +: LW]);
            ph       = int'(cp[i*PW +: PW]);
            rel[i]   = 0;
            write[i] = 1'b0;
            if (accepted && cv[i]) begin
                if (seen[lg]) begin
                    rel[i] = ph;
                end else begin
                    rel[i]   = model[lg];
                    seen[lg] = 1'b1;
                    write[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < CW; i++) begin
            push($sformatf("rel_valid%0d", i), (accepted && cv[i]) ? 32'd1 : 32'd0);
            if (accepted && cv[i]) push($sformatf("rel_phy%0d", i), 32'(rel[i]));
        end
        for (int i = 0; i < CW; i++) begin
            if (write[i]) model[int'(cl[i*LW +: LW])] = int'(cp[i*PW +: PW]);
        end
    endtask

    task automatic consume_commits(input bit accepted);
        for (int i = 0; i < CW; i++) begin
            pop_check(32'(release_valid_o[i]));
            if (accepted && cv[i]) pop_check(32'(release_phy_o[i*PW +: PW]));
        end
    endtask

    task automatic commit_eval();
        expect_commits(1'b1);
        #2;
        consume_commits(1'b1);
    endtask

    // Issue a recovery request in the current cycle (together with any lanes
    // the caller already drove) and check the whole walk. With noise set, every
    // walk cycle also carries full commits and a new request, all to be ignored.
    // abort_group >= 0 asserts reset in that walk cycle.
    task automatic run_walk(input bit noise, input int abort_group);
        bit had_commits;
        had_commits = (cv != '0);
        req = 1'b1;
        if (had_commits) expect_commits(1'b1);
        for (int g = 0; g < G; g++) begin
            push($sformatf("g%0d_busy", g), 32'd1);
            push($sformatf("g%0d_done", g), (g == G - 1) ? 32'd1 : 32'd0);
            for (int k = 0; k < RW; k++) begin
                int idx;
                idx = g * RW + k;
                push($sformatf("g%0d_valid%0d", g, k), (idx < NL) ? 32'd1 : 32'd0);
                if (idx < NL) begin
                    push($sformatf("g%0d_log%0d", g, k), 32'(idx));
                    push($sformatf("g%0d_phy%0d", g, k), 32'(model[idx]));
                end
            end
        end
        #2;
        if (had_commits) consume_commits(1'b1);
        step();
        req = 1'b0;
        cv  = '0;
        for (int g = 0; g < G; g++) begin
            if (noise) begin
                req = 1'b1;
                for (int i = 0; i < CW; i++) drive_lane(i, 1'b1, i + 1, 90 + i);
            end
            #2;
            pop_check(32'(recover_busy_o));
            pop_check(32'(recover_done_o));
            for (int k = 0; k < RW; k++) begin
                pop_check(32'(recover_valid_o[k]));
                if (g * RW + k < NL) begin
                    pop_check(32'(recover_log_o[k*LW +: LW]));
                    pop_check(32'(recover_phy_o[k*PW +: PW]));
                end
            end
            if (noise) check($sformatf("walk_rel_valid_g%0d", g), 32'(release_valid_o), 32'd0);
            if (g == abort_group) begin
                #1;
                reset = 1'b1;
                #1;
                check("abort_busy", 32'(recover_busy_o), 32'd0);
                check("abort_done", 32'(recover_done_o), 32'd0);
                check("abort_valid", 32'(recover_valid_o), 32'd0);
                sb_tag.delete();
                sb_exp.delete();
                model_identity();
                req = 1'b0;
                cv  = '0;
                step();
                reset = 1'b0;
                return;
            end
            step();
            req = 1'b0;
            cv  = '0;
        end
        #2;
        check("post_walk_busy", 32'(recover_busy_o), 32'd0);
        check("post_walk_done", 32'(recover_done_o), 32'd0);
        check("post_walk_valid", 32'(recover_valid_o), 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        cv    = '0;
        cl    = '0;
        cp    = '0;
        req   = 1'b0;
        model_identity();

        #12;
        check("rst_busy", 32'(recover_busy_o), 32'd0);
        check("rst_done", 32'(recover_done_o), 32'd0);
        check("rst_rcv_valid", 32'(recover_valid_o), 32'd0);
        check("rst_rel_valid", 32'(release_valid_o), 32'd0);
        step();
        reset = 1'b0;
        #2;
        check("idle_busy", 32'(recover_busy_o), 32'd0);
        check("idle_done", 32'(recover_done_o), 32'd0);
        check("idle_rcv_valid", 32'(recover_valid_o), 32'd0);
        check("idle_rel_valid", 32'(release_valid_o), 32'd0);
        step();

        // Identity walk straight out of reset.
        run_walk(1'b0, -1);

        // Lane 2 supersedes lane 0 on r5.
        drive_lane(0, 1'b1, 5, 40);
        drive_lane(2, 1'b1, 5, 41);
        commit_eval();
        check("sup_lane0_phy", 32'(release_phy_o[0*PW +: PW]), 32'd40);
        check("sup_lane2_phy", 32'(release_phy_o[2*PW +: PW]), 32'd5);
        step();
        cv = '0;

        // Invalid younger lane on r7 must not suppress lane 1.
        drive_lane(1, 1'b1, 7, 50);
        drive_lane(3, 1'b0, 7, 51);
        commit_eval();
        check("inv_lane1_phy", 32'(release_phy_o[1*PW +: PW]), 32'd7);
        check("inv_lane3_valid", 32'(release_valid_o[3]), 32'd0);
        step();
        cv = '0;

        // Commit in the request cycle is visible to group 0.
        drive_lane(0, 1'b1, 3, 60);
        run_walk(1'b0, -1);

        // Commits and requests during the walk are ignored.
        run_walk(1'b1, -1);
        run_walk(1'b0, -1);

        // Random bursts over a narrow register range to force collisions.
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < CW; i++) begin
                drive_lane(i, 1'(($urandom_range(3) != 0) ? 1 : 0),
                           int'($urandom_range(7)), int'($urandom_range(NP - 1)));
            end
            commit_eval();
            step();
            cv = '0;
        end
        run_walk(1'b0, -1);

        // Reset in the fourth walk cycle, then a clean walk from entry 0.
        run_walk(1'b0, 3);
        run_walk(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
